// File: rtl/cam_stream_pkg.sv
// Shared types for the OV7670 capture front end: FSM states, the pixel beat
// carried through the output FIFO, and the RGB565 byte-order rule.
package cam_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    ACTIVE
  } state_t;

  typedef struct packed {
    logic [15:0] tdata;
    logic        tuser;
    logic        tlast;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

  // The camera sends the high half of each RGB565 pixel first.
  localparam bit FIRST_BYTE_HIGH = 1'b1;

  function automatic logic [15:0] pack_rgb565(input logic [7:0] first, input logic [7:0] second);
    return FIRST_BYTE_HIGH ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/cam_pixel_fifo.sv
// FWFT pixel FIFO with a registered output slot; a write reaches out_vld one cycle later.
// Capacity is DEPTH entries including the output slot; a push while full is accepted only alongside a pop.
module cam_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_ok,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic [CW-1:0] total;
  logic          full;
  logic          pop;
  logic          load;

  assign total   = mem_cnt + {{AW{1'b0}}, out_vld};
  assign full    = (total == CW'(DEPTH));
  assign pop     = out_vld && out_rdy;
  assign push_ok = push_vld && (!full || pop);
  assign load    = (mem_cnt != '0) && (!out_vld || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        out_dat <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        out_vld <= 1'b1;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
      case ({push_ok, load})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_stream_capture.sv
// Samples the OV7670 DVP bus in the ACLK domain, pairs bytes into RGB565 and streams them out.
// Second-byte pclk edge to tvalid is SYNC_STAGES+3 cycles; a full FIFO drops pixels and counts them.
module ov7670_stream_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        capture_en,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [31:0] frame_count,
  output logic [15:0] overflow_count,
  output logic        line_err,
  output logic        busy
);
  import cam_stream_pkg::*;

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);

  logic [10:0]   sync_q [SYNC_STAGES];
  logic          pclk_s, vsync_s, href_s;
  logic [7:0]    data_s;
  logic          pclk_prev, vsync_prev, href_prev;
  logic          pclk_rise, vsync_fall, vsync_rise;
  state_t        state, state_nxt;
  logic          frame_done;
  logic          sof_pending;
  logic          byte_phase;
  logic [7:0]    hi_byte;
  logic [XW-1:0] pixel_x;
  logic          push_vld, push_ok;
  pixel_t        push_dat, fifo_dat;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {cam_pclk, cam_vsync, cam_href, cam_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {pclk_s, vsync_s, href_s, data_s} = sync_q[SYNC_STAGES-1];
  assign pclk_rise  = pclk_s && !pclk_prev;
  assign vsync_fall = pclk_rise && vsync_prev && !vsync_s;
  assign vsync_rise = pclk_rise && !vsync_prev && vsync_s;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // A frame already in progress always runs to its vsync; capture_en only picks the next one.
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (capture_en) state_nxt = WAIT_VS;
      WAIT_VS: if (vsync_fall) state_nxt = ACTIVE;
      ACTIVE: begin
        if (vsync_rise) begin
          frame_done = 1'b1;
          state_nxt  = capture_en ? WAIT_VS : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pclk_prev      <= 1'b0;
      vsync_prev     <= 1'b0;
      href_prev      <= 1'b0;
      sof_pending    <= 1'b0;
      byte_phase     <= 1'b0;
      hi_byte        <= '0;
      pixel_x        <= '0;
      push_vld       <= 1'b0;
      push_dat       <= '0;
      frame_count    <= '0;
      overflow_count <= '0;
      line_err       <= 1'b0;
    end else begin
      pclk_prev <= pclk_s;
      push_vld  <= 1'b0;
      if (pclk_rise) begin
        vsync_prev <= vsync_s;
        href_prev  <= href_s;
      end
      if (frame_done) frame_count <= frame_count + 32'd1;
      if (push_vld && !push_ok && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;

      // A dropped start-of-frame pixel keeps sof_pending so the next accepted pixel carries tuser.
      if (state == WAIT_VS && vsync_fall) sof_pending <= 1'b1;
      else if (push_ok && push_dat.tuser) sof_pending <= 1'b0;

      if (state != ACTIVE) begin
        pixel_x    <= '0;
        byte_phase <= 1'b0;
      end else if (pclk_rise) begin
        if (href_s) begin
          if (!byte_phase) begin
            hi_byte    <= data_s;
            byte_phase <= 1'b1;
          end else begin
            byte_phase <= 1'b0;
            if (pixel_x < X_END) begin
              push_vld       <= 1'b1;
              push_dat.tdata <= pack_rgb565(hi_byte, data_s);
              push_dat.tuser <= sof_pending;
              push_dat.tlast <= (pixel_x == X_LAST);
              pixel_x        <= pixel_x + 1'b1;
            end else begin
              line_err <= 1'b1;
            end
          end
        end else if (href_prev) begin
          if (pixel_x != X_END || byte_phase) line_err <= 1'b1;
          pixel_x    <= '0;
          byte_phase <= 1'b0;
        end
      end
    end
  end

  cam_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIXEL_W)
  ) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_ok  (push_ok),
    .out_vld  (m_axis_tvalid),
    .out_dat  (fifo_dat),
    .out_rdy  (m_axis_tready)
  );

  assign m_axis_tdata = fifo_dat.tdata;
  assign m_axis_tuser = fifo_dat.tuser;
  assign m_axis_tlast = fifo_dat.tlast;
  assign busy         = (state == ACTIVE);

endmodule

// File: tb/tb_ov7670_stream_capture.sv
// Scoreboarded bench for ov7670_stream_capture: a frame-level camera model queues the
// expected beats, and an independent monitor pops and compares every accepted beat.
module tb_ov7670_stream_capture;

  localparam int H     = 4;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        tready = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [31:0] frame_count;
  logic [15:0] overflow_count;
  logic        line_err;
  logic        busy;

  ov7670_stream_capture #(
    .H_ACTIVE    (H),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .capture_en     (capture_en),
    .cam_pclk       (cam_pclk),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_href),
    .cam_data       (cam_data),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (tready),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .frame_count    (frame_count),
    .overflow_count (overflow_count),
    .line_err       (line_err),
    .busy           (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_b, exp_b;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_rise_cyc = 0;
  bit    lat_armed = 1'b0;
  int    rdy_mode = 1;
  int    exp_ovf = 0;
  bit    sof = 1'b0;
  int    kept = 0;
  bit    pattern_mode = 1'b0;
  int    pat_idx = 0;
  logic  prev_vld = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must be the next one the camera model predicted.
  always @(negedge ACLK) begin
    if (lat_armed && m_axis_tvalid && !prev_vld) begin
      lat_armed = 1'b0;
      check("latency", cyc - last_rise_cyc, SYNC + 3);
    end
    prev_vld = m_axis_tvalid;
    if (m_axis_tvalid && tready) begin
      got_b = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        check("beat", {14'd0, got_b}, {14'd0, exp_b});
      end
    end
  end

  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      case (rdy_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic pclk_tick(input logic vs, input logic hr, input logic [7:0] d);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    cam_pclk  = 1'b0;
    cycles(4);
    cam_pclk      = 1'b1;
    last_rise_cyc = cyc;
    cycles(4);
  endtask

  function automatic logic [7:0] next_byte();
    logic [7:0] b;
    if (pattern_mode) begin
      b = 8'h12 + 8'(8'h22 * pat_idx);
      pat_idx++;
    end else begin
      b = 8'($urandom);
    end
    return b;
  endfunction

  // Pixel k of a captured line is {first, second}; only the first H per line exist,
  // tlast marks k == H-1, and a bounded keep models a FIFO that is never drained.
  task automatic send_line(input int nbytes, input bit cap, input int keep, input bit arm);
    logic [7:0] b0, b1;
    beat_t      e;
    for (int k = 0; k < nbytes / 2; k++) begin
      b0 = next_byte();
      pclk_tick(1'b0, 1'b1, b0);
      b1 = next_byte();
      if (cap && k < H) begin
        if (keep < 0 || kept < keep) begin
          e.d = {b0, b1};
          e.u = sof;
          e.l = (k == H - 1);
          exp_q.push_back(e);
          sof = 1'b0;
          kept++;
        end else begin
          exp_ovf++;
        end
      end
      if (arm && k == 0) lat_armed = 1'b1;
      pclk_tick(1'b0, 1'b1, b1);
    end
    if (nbytes % 2 != 0) pclk_tick(1'b0, 1'b1, next_byte());
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input bit cap, input int keep,
                            input int en_line, input bit en_new, input bit arm);
    kept = 0;
    sof  = 1'b1;
    repeat (2) pclk_tick(1'b1, 1'b0, 8'h00);
    repeat (2) pclk_tick(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < nlines; l++) begin
      send_line((l == bad_line) ? 2 * H - 1 : 2 * H, cap, keep, arm && (l == 0));
      repeat (3) pclk_tick(1'b0, 1'b0, 8'h00);
      if (l == en_line) capture_en = en_new;
    end
    repeat (2) pclk_tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic wait_drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 3000) begin
      @(posedge ACLK);
      i++;
    end
    cycles(10);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    cycles(3);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("rst_tdata", {16'd0, m_axis_tdata}, 0);
    check("rst_tuser_tlast", {30'd0, m_axis_tuser, m_axis_tlast}, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_overflow", {16'd0, overflow_count}, 0);
    check("rst_line_err", {31'd0, line_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    ARESETN = 1'b1;
    cycles(2);

    // Known byte pattern, full-rate sink; also times the first pixel.
    capture_en   = 1'b1;
    pattern_mode = 1'b1;
    send_frame(2, -1, 1'b1, -1, -1, 1'b0, 1'b1);
    pattern_mode = 1'b0;
    wait_drain();
    check("t1_frame_count", frame_count, 1);
    check("t1_line_err", {31'd0, line_err}, 0);
    check("t1_overflow", {16'd0, overflow_count}, 0);
    check("t1_busy", {31'd0, busy}, 0);

    // Sink stalled for the whole frame: only DEPTH pixels survive.
    rdy_mode = 0;
    send_frame(2, -1, 1'b1, DEPTH, -1, 1'b0, 1'b0);
    cycles(20);
    check("t2_overflow", {16'd0, overflow_count}, exp_ovf);
    check("t2_tvalid_held", {31'd0, m_axis_tvalid}, 1);
    rdy_mode = 2;
    wait_drain();
    check("t2_frame_count", frame_count, 2);
    check("t2_line_err", {31'd0, line_err}, 0);

    // Short line with an odd trailing byte, random backpressure.
    send_frame(2, 0, 1'b1, -1, -1, 1'b0, 1'b0);
    wait_drain();
    check("t3_line_err", {31'd0, line_err}, 1);
    check("t3_frame_count", frame_count, 3);
    check("t3_overflow", {16'd0, overflow_count}, exp_ovf);

    // Enable dropped after the first line: frame still completes, then nothing.
    send_frame(2, -1, 1'b1, -1, 0, 1'b0, 1'b0);
    wait_drain();
    check("t4_frame_count", frame_count, 4);
    check("t4_busy", {31'd0, busy}, 0);
    send_frame(2, -1, 1'b0, -1, -1, 1'b0, 1'b0);
    wait_drain();
    check("t4_idle_frame_count", frame_count, 4);

    // Enable raised mid-frame: that frame is skipped, the next one starts with tuser.
    send_frame(2, -1, 1'b0, -1, 0, 1'b1, 1'b0);
    wait_drain();
    check("t5_skip_frame_count", frame_count, 4);
    send_frame(2, -1, 1'b1, -1, -1, 1'b0, 1'b0);
    wait_drain();
    check("t5_frame_count", frame_count, 5);

    // Reset pulse while ACTIVE with pixels waiting.
    rdy_mode = 0;
    repeat (2) pclk_tick(1'b1, 1'b0, 8'h00);
    repeat (2) pclk_tick(1'b0, 1'b0, 8'h00);
    send_line(2 * H, 1'b0, -1, 1'b0);
    pclk_tick(1'b0, 1'b0, 8'h00);
    check("t6_pre_busy", {31'd0, busy}, 1);
    check("t6_pre_tvalid", {31'd0, m_axis_tvalid}, 1);
    ARESETN = 1'b0;
    cycles(1);
    check("t6_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("t6_frame_count", frame_count, 0);
    check("t6_overflow", {16'd0, overflow_count}, 0);
    check("t6_line_err", {31'd0, line_err}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    ARESETN  = 1'b1;
    exp_ovf  = 0;
    rdy_mode = 1;
    repeat (2) pclk_tick(1'b1, 1'b0, 8'h00);
    send_frame(1, -1, 1'b1, -1, -1, 1'b0, 1'b0);
    wait_drain();
    check("t6_after_frame_count", frame_count, 1);
    check("t6_after_line_err", {31'd0, line_err}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
